// File: rtl/cve2_mac_result_collector.sv
// MAC result collector: captures product and sum around the ALU, returns the result to writeback; CVE2_MAC_SAT_EN adds signed saturation.
// Latency: start at cycle 0, product at 1, ADD override at 2, result valid from 3; one MAC per 3 cycles back-to-back.
// Backpressure: result held stable in HOLD until ready; starts arriving while busy are dropped and flagged on drop_o.
module cve2_mac_result_collector #(
    parameter int unsigned Width    = 32,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                kill_i,
    input  logic [Width-1:0]    acc_operand_i,
    input  logic [Width-1:0]    alu_result_i,
    output logic                op_override_o,
    output logic [Width-1:0]    op_a_o,
    output logic [Width-1:0]    op_b_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [Width-1:0]    result_o,
    output logic                sat_o,
    output logic                busy_o,
    output logic                drop_o,
    output logic [CntWidth-1:0] mac_count_o
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, HOLD} state_e;

    state_e              state_q, state_d;
    logic [Width-1:0]    acc_q, acc_d;
    logic [Width-1:0]    prod_q, prod_d;
    logic [Width-1:0]    res_q, res_d;
    logic                sat_q, sat_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic [Width-1:0]    add_res;
    logic                add_sat;
    logic                start_ok;

`ifdef CVE2_MAC_SAT_EN
    // Overflow only possible when both operands share a sign and the sum flips it.
    always_comb begin
        add_res = alu_result_i;
        add_sat = 1'b0;
        if ((prod_q[Width-1] == acc_q[Width-1]) &&
            (alu_result_i[Width-1] != prod_q[Width-1])) begin
            add_sat = 1'b1;
            add_res = prod_q[Width-1] ? {1'b1, {(Width-1){1'b0}}}
                                      : {1'b0, {(Width-1){1'b1}}};
        end
    end
`else
    assign add_res = alu_result_i;
    assign add_sat = 1'b0;
`endif

    assign start_ok = start_i && !kill_i;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        res_d   = res_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    acc_d   = acc_operand_i;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    prod_d  = alu_result_i;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    res_d   = add_res;
                    sat_d   = add_sat;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (result_ready_i) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (start_i) begin
                        acc_d   = acc_operand_i;
                        state_d = MUL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state; stale captured data never leaks out.
    assign op_override_o  = (state_q == ADD);
    assign op_a_o         = op_override_o ? prod_q : '0;
    assign op_b_o         = op_override_o ? acc_q : '0;
    assign result_valid_o = (state_q == HOLD);
    assign result_o       = result_valid_o ? res_q : '0;
    assign sat_o          = result_valid_o && sat_q;
    assign busy_o         = (state_q != IDLE);
    assign mac_count_o    = cnt_q;
    assign drop_o         = !rst_i && start_ok &&
                            ((state_q == MUL) || (state_q == ADD) ||
                             ((state_q == HOLD) && !result_ready_i));

endmodule

// File: tb/tb_cve2_mac_result_collector.sv
// Bench for cve2_mac_result_collector: cycle vector table for the directed cases, then a scoreboarded back-to-back run through counter wrap.
module tb_cve2_mac_result_collector;

    localparam int W     = 32;
    localparam int CNT_W = 8;
    localparam int NMAC  = 256;

`ifdef CVE2_MAC_SAT_EN
    localparam logic [31:0] SAT_RES = 32'h7FFF_FFFF;
    localparam logic        SAT_FLG = 1'b1;
`else
    localparam logic [31:0] SAT_RES = 32'h9000_0000;
    localparam logic        SAT_FLG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, kill, rdy;
    logic [W-1:0]     acc, alu;
    logic             ovr, vld, sat, busy, drop;
    logic [W-1:0]     op_a, op_b, res;
    logic [CNT_W-1:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cve2_mac_result_collector #(.Width(W), .CntWidth(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .kill_i         (kill),
        .acc_operand_i  (acc),
        .alu_result_i   (alu),
        .op_override_o  (ovr),
        .op_a_o         (op_a),
        .op_b_o         (op_b),
        .result_valid_o (vld),
        .result_ready_i (rdy),
        .result_o       (res),
        .sat_o          (sat),
        .busy_o         (busy),
        .drop_o         (drop),
        .mac_count_o    (cnt)
    );

    typedef struct {
        logic        rst, start, kill;
        logic [31:0] acc, alu;
        logic        rdy;
        logic        ovr;
        logic [31:0] a, b;
        logic        vld;
        logic [31:0] res;
        logic        sat, busy, drop;
        logic [7:0]  cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] sbq[$];

    function automatic vec_t mk(input logic r, input logic s, input logic k,
                                input logic [31:0] ac, input logic [31:0] al, input logic rd,
                                input logic ov, input logic [31:0] ea, input logic [31:0] eb,
                                input logic ev, input logic [31:0] er, input logic es,
                                input logic eb_busy, input logic ed, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.start = s; v.kill = k; v.acc = ac; v.alu = al; v.rdy = rd;
        v.ovr = ov; v.a = ea; v.b = eb; v.vld = ev; v.res = er; v.sat = es;
        v.busy = eb_busy; v.drop = ed; v.cnt = ec;
        return v;
    endfunction

    // Reference: {sat, result} from product and accumulator, sum as the ALU would form it.
    function automatic logic [32:0] model(input logic [31:0] p, input logic [31:0] a);
        logic [31:0] s;
        logic        ov;
        s  = p + a;
        ov = (p[31] == a[31]) && (s[31] != p[31]);
`ifdef CVE2_MAC_SAT_EN
        if (ov) return {1'b1, (p[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
`endif
        return {1'b0, s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pa, pp, ps;
        logic [32:0] e;

        rst = 1'b1; start = 1'b0; kill = 1'b0; rdy = 1'b0; acc = '0; alu = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //          rst st kl acc            alu            rdy ovr a             b             vld res      sat      busy drop cnt
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            0, 0,       0,       0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5,            0,            0, 0, 0,            0,            0, 0,       0,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            12,           0, 0, 0,            0,            0, 0,       0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            17,           0, 1, 12,           5,            0, 0,       0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            1, 17,      0,       1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 9,            0,            0, 0, 0,            0,            1, 17,      0,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            1, 17,      0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            1, 17,      0,       1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 100,          0,            1, 0, 0,            0,            1, 17,      0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            7,            0, 0, 0,            0,            0, 0,       0,       1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,            107,          0, 1, 7,            100,          0, 0,       0,       1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,            0,            1, 0, 0,            0,            1, 107,     0,       1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 3,            0,            0, 0, 0,            0,            0, 0,       0,       0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,            4,            0, 0, 0,            0,            0, 0,       0,       1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0,            7,            0, 1, 4,            3,            0, 0,       0,       1, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0,            0,            0, 0, 0,            0,            0, 0,       0,       0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 32'h2000_0000, 0,           0, 0, 0,            0,            0, 0,       0,       0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,            32'h7000_0000, 0, 0, 0,           0,            0, 0,       0,       1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,            32'h9000_0000, 0, 1, 32'h7000_0000, 32'h2000_0000, 0, 0,  0,       1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            1, SAT_RES, SAT_FLG, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0,            0,            0, 0, 0,            0,            1, SAT_RES, SAT_FLG, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0,            0, 0,       0,       0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; kill = tbl[i].kill;
            acc = tbl[i].acc; alu = tbl[i].alu; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("r%0d.ovr", i),  64'(ovr),  64'(tbl[i].ovr));
            chk($sformatf("r%0d.op_a", i), 64'(op_a), 64'(tbl[i].a));
            chk($sformatf("r%0d.op_b", i), 64'(op_b), 64'(tbl[i].b));
            chk($sformatf("r%0d.vld", i),  64'(vld),  64'(tbl[i].vld));
            chk($sformatf("r%0d.res", i),  64'(res),  64'(tbl[i].res));
            chk($sformatf("r%0d.sat", i),  64'(sat),  64'(tbl[i].sat));
            chk($sformatf("r%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("r%0d.drop", i), 64'(drop), 64'(tbl[i].drop));
            chk($sformatf("r%0d.cnt", i),  64'(cnt),  64'(tbl[i].cnt));
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; kill = 1'b0; rdy = 1'b0; acc = '0; alu = '0;

        // Back-to-back MACs with random operands, enough completions to wrap the counter.
        for (int i = 0; i < NMAC; i++) begin
            pa = $urandom;
            pp = $urandom;
            ps = pp + pa;
            start = 1'b1; acc = pa; rdy = (i > 0);
            #1;
            if (i > 0) begin
                e = sbq.pop_front();
                chk($sformatf("b2b%0d.vld", i), 64'(vld), 64'd1);
                chk($sformatf("b2b%0d.res", i), 64'(res), 64'(e[31:0]));
                chk($sformatf("b2b%0d.sat", i), 64'(sat), 64'(e[32]));
                chk($sformatf("b2b%0d.cnt", i), 64'(cnt), 64'((i - 1) & 8'hFF));
            end
            sbq.push_back(model(pp, pa));
            @(negedge clk);
            start = 1'b0; rdy = 1'b0; alu = pp;
            #1;
            chk($sformatf("b2b%0d.mulbusy", i), 64'(busy), 64'd1);
            @(negedge clk);
            alu = ps;
            #1;
            chk($sformatf("b2b%0d.ovr", i), 64'(ovr), 64'd1);
            @(negedge clk);
        end
        rdy = 1'b1;
        #1;
        e = sbq.pop_front();
        chk("last.vld", 64'(vld), 64'd1);
        chk("last.res", 64'(res), 64'(e[31:0]));
        chk("last.sat", 64'(sat), 64'(e[32]));
        chk("last.cnt", 64'(cnt), 64'(NMAC - 1));
        @(negedge clk);
        rdy = 1'b0;
        #1;
        chk("wrap.cnt", 64'(cnt), 64'd0);
        chk("wrap.busy", 64'(busy), 64'd0);
        chk("wrap.sbq_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cve2_mac_result_collector.md
# cve2_mac_result_collector

Receive-side companion to the MAC operator sequencer in the cve2 execute stage. The sequencer steers the ALU through a MUL phase and then an ADD phase. This block:
- captures the multiply product;
- feeds product and accumulator back to the ALU as operands for the ADD phase;
- captures the sum;
- presents the final MAC result to writeback over a valid/ready handshake.

It also counts completed MACs and flags dropped requests.

## Interface
Parameters:
- `Width`, 32: datapath width of operands/results.
- `CntWidth`, 16: width of completed-MAC counter.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  MAC request pulse, aligned with the sequencer's MUL-enable cycle.
- `kill_i`  in  1  abort in-flight MAC (pipeline flush).
- `acc_operand_i`  in  Width  accumulator value (old rd), sampled on accepted start.
- `alu_result_i`  in  Width  ALU result bus.
- `op_override_o`  out  1  ALU operand override enable (ADD phase only).
- `op_a_o`  out  Width  override operand A (captured product).
- `op_b_o`  out  Width  override operand B (captured accumulator).
- `result_valid_o`  out  1  MAC result available.
- `result_ready_i`  in  1  writeback accepts result.
- `result_o`  out  Width  MAC result.
- `sat_o`  out  1  result was saturated; qualified by `result_valid_o`.
- `busy_o`  out  1  state != IDLE.
- `drop_o`  out  1  one-cycle pulse: start_i ignored.
- `mac_count_o`  out  CntWidth  completed handshakes.

## Operation
States: IDLE, MUL, ADD, HOLD.

State transitions:
- **IDLE**
  - `start_i && !kill_i`: capture `acc_operand_i` into `acc_q`, then go to MUL.
  - `kill_i` wins over a simultaneous `start_i`; no capture, no drop pulse.
- **MUL**
  - Capture `alu_result_i` into `prod_q`, then go to ADD.
- **ADD**
  - `op_override_o`=1, `op_a_o`=`prod_q`, `op_b_o`=`acc_q`.
  - Capture `alu_result_i` (after optional saturation) into `res_q`, set `sat_q`, then go to HOLD.
- **HOLD**
  - `result_valid_o`=1, `result_o`=`res_q`, `sat_o`=`sat_q`.
  - On `result_ready_i`: increment `mac_count_o`, then go to IDLE.
  - If `start_i` arrives in the same cycle as `result_ready_i`, capture `acc_operand_i` and go directly to MUL (back-to-back MACs).

Rules that apply in every state:
- `kill_i` in MUL/ADD/HOLD: go to IDLE next cycle. No valid, no count increment. Captured registers keep stale data, but outputs are gated.
- `start_i` in MUL or ADD, or in HOLD without `result_ready_i`: ignored, and `drop_o`=1 for that cycle.
- `op_a_o`/`op_b_o` are driven 0 whenever `op_override_o`=0.
- `result_o`/`sat_o` are driven 0 whenever `result_valid_o`=0.
- `mac_count_o` wraps from 2^CntWidth-1 to 0.
- Arithmetic: two's complement, Width bits. No sign extension; the product is the low Width bits supplied by the ALU.

## Timing
- Reset (`rst_i`=1 at a clock edge, in any state): state=IDLE next cycle. Every output is 0: `op_override_o`, `op_a_o`, `op_b_o`, `result_valid_o`, `result_o`, `sat_o`, `busy_o`, `drop_o`, `mac_count_o`. `acc_q`, `prod_q` and `res_q` are cleared. Reset overrides every other input.
- Latency: `start_i` accepted at cycle 0, product sampled at cycle 1, override active at cycle 2, `result_valid_o` high from cycle 3.
- Throughput: one MAC per 3 cycles with back-to-back start in HOLD.
- `result_valid_o` stays high and `result_o` stays stable until `result_ready_i` or `kill_i`. Valid never depends combinationally on ready.
- `op_override_o` and `busy_o` are decoded from registered state. `drop_o` is combinational from `start_i` and state.

## Configuration
Macro: `CVE2_MAC_SAT_EN`.
- **Defined:** in ADD, signed overflow is detected when `prod_q[MSB]`==`acc_q[MSB]` and `alu_result_i[MSB]`!=`prod_q[MSB]`. On overflow, `res_q` is clamped to 0x7FFF_FFFF (positive operands) or 0x8000_0000 (negative operands) and `sat_q`=1.
- **Not defined:** `res_q`=`alu_result_i` (wrapping), `sat_o` tied 0, and no overflow logic is synthesised.

## Test plan
- Basic: `acc_operand_i`=5, then `alu_result_i`=12 in MUL and 17 in ADD. Required: `op_a_o`=12 and `op_b_o`=5 at cycle 2; `result_o`=17 and `result_valid_o`=1 at cycle 3; `mac_count_o`=1 after ready.
- Backpressure: hold `result_ready_i`=0 for 4 cycles → `result_o` stays 17 and valid stays high. A `start_i` during the stall gives `drop_o`=1. Ready together with start → next MAC enters MUL the following cycle, `mac_count_o` increments.
- Kill: `kill_i` during ADD → IDLE next cycle, `result_valid_o` never asserts, `mac_count_o` unchanged. `start_i`+`kill_i` in IDLE → remains IDLE, `drop_o`=0.
- Saturation (with macro): product 0x7000_0000, acc 0x2000_0000, ALU sum 0x9000_0000 → `result_o`=0x7FFF_FFFF, `sat_o`=1. Without macro → `result_o`=0x9000_0000, `sat_o`=0.
- Reset mid-operation: assert `rst_i` in HOLD → all outputs 0 next cycle, `mac_count_o`=0.
- Counter wrap: force 65536 completions (CntWidth=16) → `mac_count_o` returns to 0.
